// File: rtl/cdc_sync_bank.sv
// Bank of asynchronous-input synchronisers with a glitch filter,
// mode-selectable edge detection, sticky flags and saturating event counters.
module cdc_sync_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      kill,
  input  logic [CHANNELS-1:0]       async_in,
  input  logic [2*CHANNELS-1:0]     edge_mode,
  input  logic [CHANNELS-1:0]       clr_sticky,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       sync_out,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CHANNELS*CNT_W-1:0] event_cnt
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_sync_bank: SYNC_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filt
    $error("cdc_sync_bank: FILTER_LEN must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          fcnt_q;
    logic                   filt_q;
    logic                   filt_d_q;
    logic                   pulse_q;
    logic                   sticky_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   last;
    logic                   rise;
    logic                   fall;
    logic                   ev;

    // Pure flop chain: bit 0 is the capture stage, no logic in between.
    always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], async_in[i]};
      end
    end

    assign last = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
        fcnt_q <= '0;
        filt_q <= 1'b0;
      end else if (last != filt_q) begin
        if (fcnt_q == F_LAST) begin
          fcnt_q <= '0;
          filt_q <= last;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end

    assign rise = filt_q & ~filt_d_q & edge_mode[2*i];
    assign fall = ~filt_q & filt_d_q & edge_mode[2*i+1];
    assign ev   = rise | fall;

    always_ff @(posedge clk or posedge kill) begin
      if (kill) begin
        filt_d_q <= 1'b0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        filt_d_q <= filt_q;
        pulse_q  <= ev;
        sticky_q <= ev | (sticky_q & ~clr_sticky[i]);
        if (cnt_clr) begin
          cnt_q <= '0;
        end else if (ev && cnt_q != C_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign sync_out[i]                  = filt_q;
    assign pulse_out[i]                 = pulse_q;
    assign sticky[i]                    = sticky_q;
    assign event_cnt[CNT_W*i +: CNT_W]  = cnt_q;
  end

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Directed bench for cdc_sync_bank: latency, glitch rejection, masking,
// saturation, asynchronous kill and a random multi-channel run.
module tb_cdc_sync_bank;

  logic        clk = 1'b0;
  logic        kill;
  logic [3:0]  async_in;
  logic [7:0]  edge_mode;
  logic [3:0]  clr_sticky;
  logic        cnt_clr;
  logic [3:0]  sync_out;
  logic [3:0]  pulse_out;
  logic [3:0]  sticky;
  logic [15:0] event_cnt;

  int checks = 0;
  int failures = 0;

  cdc_sync_bank #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(4)
  ) dut (
    .clk(clk), .kill(kill), .async_in(async_in),
    .edge_mode(edge_mode), .clr_sticky(clr_sticky), .cnt_clr(cnt_clr),
    .sync_out(sync_out), .pulse_out(pulse_out), .sticky(sticky),
    .event_cnt(event_cnt)
  );

  always #50 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(event_cnt[4*ch +: 4]);
  endfunction

  initial begin
    int np;
    int exp_cnt[4];
    int hold[4];
    logic [3:0] rise_en;
    logic [3:0] fall_en;

    kill = 1'b1;
    async_in = '0;
    edge_mode = 8'b11_10_11_01;
    rise_en = 4'b1011;
    fall_en = 4'b1110;
    clr_sticky = '0;
    cnt_clr = 1'b0;
    step();
    step();
    chk("rst_sync", 32'(sync_out), 0);
    chk("rst_pulse", 32'(pulse_out), 0);
    chk("rst_sticky", 32'(sticky), 0);
    chk("rst_cnt", 32'(event_cnt), 0);
    kill = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // 1: latency on channel 0
    async_in[0] = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    chk("lat_sync_e5", 32'(sync_out[0]), 0);
    step();
    chk("lat_sync_e6", 32'(sync_out[0]), 1);
    chk("lat_pulse_e6", 32'(pulse_out[0]), 0);
    step();
    chk("lat_pulse_e7", 32'(pulse_out), 1);
    chk("lat_sticky_e7", 32'(sticky[0]), 1);
    chk("lat_cnt_e7", cnt_of(0), 1);
    step();
    chk("lat_pulse_e8", 32'(pulse_out[0]), 0);
    for (int k = 0; k < 12; k++) step();

    // 2: glitch rejection on channel 1
    async_in[1] = 1'b1;
    np = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (pulse_out != 0) np++;
    end
    async_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (pulse_out != 0) np++;
    end
    chk("glitch_pulses", 32'(np), 0);
    chk("glitch_sync", 32'(sync_out[1]), 0);
    chk("glitch_cnt", cnt_of(1), 0);
    chk("glitch_sticky", 32'(sticky[1]), 0);
    async_in[1] = 1'b1;
    np = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (pulse_out[1]) np++;
    end
    async_in[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (pulse_out[1]) np++;
    end
    chk("pw4_pulses", 32'(np), 2);
    chk("pw4_cnt", cnt_of(1), 2);

    // 3: fall-only mode and sticky set-wins on channel 2
    async_in[2] = 1'b1;
    np = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (pulse_out[2]) np++;
    end
    chk("mask_rise_pulses", 32'(np), 0);
    chk("mask_rise_sync", 32'(sync_out[2]), 1);
    async_in[2] = 1'b0;
    np = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (pulse_out[2]) np++;
    end
    chk("mask_fall_pulses", 32'(np), 1);
    chk("mask_cnt", cnt_of(2), 1);
    chk("mask_sticky", 32'(sticky[2]), 1);
    clr_sticky[2] = 1'b1;
    step();
    clr_sticky[2] = 1'b0;
    chk("clr_sticky", 32'(sticky[2]), 0);
    async_in[2] = 1'b1;
    for (int k = 0; k < 12; k++) step();
    async_in[2] = 1'b0;
    for (int k = 0; k < 6; k++) step();
    clr_sticky[2] = 1'b1;
    step();
    clr_sticky[2] = 1'b0;
    chk("setwins_pulse", 32'(pulse_out[2]), 1);
    chk("setwins_sticky", 32'(sticky[2]), 1);
    chk("setwins_cnt", cnt_of(2), 2);
    step();
    chk("setwins_hold", 32'(sticky[2]), 1);

    // 4: saturation and cnt_clr on channel 3
    for (int k = 1; k <= 20; k++) begin
      async_in[3] = ~async_in[3];
      for (int j = 0; j < 8; j++) step();
      chk($sformatf("sat_cnt_%0d", k), cnt_of(3), (k < 15) ? k : 15);
    end
    async_in[3] = ~async_in[3];
    for (int k = 0; k < 6; k++) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cclr_pulse", 32'(pulse_out[3]), 1);
    chk("cclr_sticky", 32'(sticky[3]), 1);
    chk("cclr_cnt", 32'(event_cnt), 0);
    step();
    chk("cclr_after", 32'(event_cnt), 0);

    // 5: asynchronous kill mid-filter and during a pulse
    async_in[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #10 kill = 1'b1;
    #1;
    chk("kill1_sync", 32'(sync_out), 0);
    chk("kill1_sticky", 32'(sticky), 0);
    chk("kill1_pulse", 32'(pulse_out), 0);
    async_in = 4'b0001;
    #20 kill = 1'b0;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (pulse_out != 0) np++;
    end
    chk("rel1_early", 32'(np), 0);
    chk("rel1_sync_e6", 32'(sync_out), 1);
    step();
    chk("rel1_pulse_e7", 32'(pulse_out), 1);
    chk("rel1_cnt_e7", 32'(event_cnt), 1);
    #10 kill = 1'b1;
    #1;
    chk("kill2_pulse", 32'(pulse_out), 0);
    chk("kill2_sticky", 32'(sticky), 0);
    chk("kill2_cnt", 32'(event_cnt), 0);
    chk("kill2_sync", 32'(sync_out), 0);
    #20 kill = 1'b0;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (pulse_out != 0) np++;
    end
    chk("rel2_early", 32'(np), 0);
    step();
    chk("rel2_pulse_e7", 32'(pulse_out), 1);
    step();
    chk("rel2_pulse_e8", 32'(pulse_out), 0);
    chk("rel2_cnt", 32'(event_cnt), 1);

    // 6: random independent toggles, each level held >= 4 cycles
    for (int k = 0; k < 10; k++) step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      exp_cnt[c] = 0;
      hold[c] = 0;
    end
    for (int t = 0; t < 200; t++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            async_in[c] = ~async_in[c];
            hold[c] = $urandom_range(3, 9);
            if ((async_in[c] && rise_en[c]) || (!async_in[c] && fall_en[c]))
              if (exp_cnt[c] < 15) exp_cnt[c]++;
          end
        end else begin
          hold[c]--;
        end
      end
      step();
    end
    for (int k = 0; k < 20; k++) step();
    for (int c = 0; c < 4; c++)
      chk($sformatf("rand_cnt_ch%0d", c), cnt_of(c), 32'(exp_cnt[c]));
    chk("rand_sync", 32'(sync_out), 32'(async_in));
    chk("rand_quiet", 32'(pulse_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
